// File: rtl/ex_reg_if.sv
// ex_reg_if: ID/EX input bundle and EX/MEM output bundle of the EX stage.
// master drives id_* and observes ex_*; slave is the EX stage itself.
interface ex_reg_if;
  logic [29:0] id_pc;
  logic        id_en_;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0;
  logic [31:0] id_alu_in_1;
  logic        id_br_flag;
  logic [1:0]  id_mem_op;
  logic [31:0] id_mem_wr_data;
  logic [1:0]  id_ctrl_op;
  logic [4:0]  id_dst_addr;
  logic        id_gpr_we_;
  logic [2:0]  id_exp_code;

  logic        ex_busy;
  logic [29:0] ex_pc;
  logic        ex_en_;
  logic        ex_br_flag;
  logic [1:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data;
  logic [1:0]  ex_ctrl_op;
  logic [4:0]  ex_dst_addr;
  logic        ex_gpr_we_;
  logic [2:0]  ex_exp_code;
  logic [31:0] ex_out;

  modport master (
    output id_pc, id_en_, id_alu_op,
    output id_alu_in_0, id_alu_in_1,
    output id_br_flag, id_mem_op,
    output id_mem_wr_data, id_ctrl_op,
    output id_dst_addr, id_gpr_we_,
    output id_exp_code,
    input  ex_busy, ex_pc, ex_en_,
    input  ex_br_flag, ex_mem_op,
    input  ex_mem_wr_data, ex_ctrl_op,
    input  ex_dst_addr, ex_gpr_we_,
    input  ex_exp_code, ex_out
  );

  modport slave (
    input  id_pc, id_en_, id_alu_op,
    input  id_alu_in_0, id_alu_in_1,
    input  id_br_flag, id_mem_op,
    input  id_mem_wr_data, id_ctrl_op,
    input  id_dst_addr, id_gpr_we_,
    input  id_exp_code,
    output ex_busy, ex_pc, ex_en_,
    output ex_br_flag, ex_mem_op,
    output ex_mem_wr_data, ex_ctrl_op,
    output ex_dst_addr, ex_gpr_we_,
    output ex_exp_code, ex_out
  );
endinterface

// File: rtl/ex_reg.sv
// ex_reg: EX stage ALU, iterative multiplier and EX/MEM register.
// Ports: clk, reset (async low), stall, flush, bus (ex_reg_if.slave);
// `EX_FWD_EN adds ex_fwd_data (ALU result for ID forwarding).
module ex_reg #(
  parameter int MUL_STEP = 1
) (
  input logic clk,
  input logic reset,
  input logic stall,
  input logic flush,
  ex_reg_if.slave bus
`ifdef EX_FWD_EN
  ,
  output logic [31:0] ex_fwd_data
`endif
);

  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_ADDS = 4'h4;
  localparam logic [3:0] OP_ADDU = 4'h5;
  localparam logic [3:0] OP_SUBS = 4'h6;
  localparam logic [3:0] OP_SUBU = 4'h7;
  localparam logic [3:0] OP_SHRL = 4'h8;
  localparam logic [3:0] OP_SHLL = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'ha;

  localparam logic [1:0] MEM_OP_NOP  = 2'h0;
  localparam logic [1:0] CTRL_OP_NOP = 2'h0;
  localparam logic [2:0] EXP_NO_EXP  = 3'h0;
  localparam logic [2:0] EXP_OVF     = 3'h3;

  localparam logic [4:0] CNT_INIT = 5'(32 / MUL_STEP - 1);

  typedef enum logic [1:0] {
    IDLE, BUSY, DONE
  } state_t;

  typedef struct packed {
    logic [29:0] pc;
    logic        en_;
    logic        br_flag;
    logic [1:0]  mem_op;
    logic [31:0] wr_data;
    logic [1:0]  ctrl_op;
    logic [4:0]  dst;
    logic        gpr_we_;
    logic [2:0]  exp_code;
    logic [31:0] out;
  } exmem_t;

  localparam exmem_t EXM_RST = '{
    pc: '0, en_: DISABLE_, br_flag: DISABLE,
    mem_op: MEM_OP_NOP, wr_data: '0,
    ctrl_op: CTRL_OP_NOP, dst: '0,
    gpr_we_: DISABLE_, exp_code: EXP_NO_EXP,
    out: '0
  };

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] prod_q, prod_d;
  exmem_t      exm_q, exm_d;

  logic [31:0] in0, in1, alu_res;
  logic [31:0] st_mc, st_mp, st_pr;
  logic        ovf, mul_req, busy;

  assign in0 = bus.id_alu_in_0;
  assign in1 = bus.id_alu_in_1;

  assign mul_req = (bus.id_en_ == ENABLE_)
                && (bus.id_alu_op == OP_MUL);

  // Gated by reset so a held MUL request does not
  // raise busy while the stage is being reset.
  assign busy = reset
             && (((state_q == IDLE) && mul_req)
              || (state_q == BUSY));

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (bus.id_alu_op)
      OP_NOP:  alu_res = in0;
      OP_AND:  alu_res = in0 & in1;
      OP_OR:   alu_res = in0 | in1;
      OP_XOR:  alu_res = in0 ^ in1;
      OP_ADDS: begin
        alu_res = in0 + in1;
        ovf = (in0[31] == in1[31])
           && (alu_res[31] != in0[31]);
      end
      OP_ADDU: alu_res = in0 + in1;
      OP_SUBS: begin
        alu_res = in0 - in1;
        ovf = (in0[31] != in1[31])
           && (alu_res[31] != in0[31]);
      end
      OP_SUBU: alu_res = in0 - in1;
      OP_SHRL: alu_res = in0 >> in1[4:0];
      OP_SHLL: alu_res = in0 << in1[4:0];
      // Product is only valid once the FSM reaches DONE.
      OP_MUL:  alu_res = (state_q == DONE) ? prod_q : '0;
      default: alu_res = '0;
    endcase
  end

  // MUL_STEP shift-add iterations; low 32 bits suffice.
  always_comb begin
    st_mc = mcand_q;
    st_mp = mplier_q;
    st_pr = prod_q;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (st_mp[0]) st_pr = st_pr + st_mc;
      st_mc = st_mc << 1;
      st_mp = st_mp >> 1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    unique case (state_q)
      IDLE: begin
        if (mul_req && !flush) begin
          state_d  = BUSY;
          cnt_d    = CNT_INIT;
          mcand_d  = in0;
          mplier_d = in1;
          prod_d   = '0;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          mcand_d  = st_mc;
          mplier_d = st_mp;
          prod_d   = st_pr;
          if (cnt_q == 5'd0) state_d = DONE;
          else cnt_d = cnt_q - 5'd1;
        end
      end
      DONE: begin
        if (flush || !stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    exm_d = exm_q;
    if (flush) begin
      exm_d = EXM_RST;
    end else if (!stall) begin
      if (busy) begin
        exm_d = EXM_RST;
      end else begin
        exm_d.pc       = bus.id_pc;
        exm_d.en_      = bus.id_en_;
        exm_d.br_flag  = bus.id_br_flag;
        exm_d.mem_op   = bus.id_mem_op;
        exm_d.wr_data  = bus.id_mem_wr_data;
        exm_d.ctrl_op  = bus.id_ctrl_op;
        exm_d.dst      = bus.id_dst_addr;
        exm_d.out      = alu_res;
        exm_d.exp_code = ovf ? EXP_OVF
                             : bus.id_exp_code;
        exm_d.gpr_we_  = (bus.id_en_ == DISABLE_)
                      || ovf ? DISABLE_
                             : bus.id_gpr_we_;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      exm_q    <= EXM_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      exm_q    <= exm_d;
    end
  end

  assign bus.ex_busy        = busy;
  assign bus.ex_pc          = exm_q.pc;
  assign bus.ex_en_         = exm_q.en_;
  assign bus.ex_br_flag     = exm_q.br_flag;
  assign bus.ex_mem_op      = exm_q.mem_op;
  assign bus.ex_mem_wr_data = exm_q.wr_data;
  assign bus.ex_ctrl_op     = exm_q.ctrl_op;
  assign bus.ex_dst_addr    = exm_q.dst;
  assign bus.ex_gpr_we_     = exm_q.gpr_we_;
  assign bus.ex_exp_code    = exm_q.exp_code;
  assign bus.ex_out         = exm_q.out;

`ifdef EX_FWD_EN
  assign ex_fwd_data = (busy || bus.id_en_ == DISABLE_)
                     ? '0 : alu_res;
`endif

endmodule
